axi_lite_cmd_master: RTL and testbench
======================================

// Module: axi_lite_cmd_master
// PURPOSE
//  AXI4-Lite master: executes one single-beat read or write per command from the JTAG command decoder.
//  Drives the on-chip AXI4-Lite register slaves, e.g. the LED register.
//  Returns read data, response code and timeout status to the decoder.
//  Strictly one outstanding transaction; no bursts, no pipelining.
// PARAMETERS
//  AXI_ADDR_WIDTH  32    address width of cmd_addr / m_axi_awaddr / m_axi_araddr
//  AXI_DATA_WIDTH  32    data width; strobe width = AXI_DATA_WIDTH/8
//  TIMEOUT_CYCLES  1024  bus cycles before a stalled transaction is aborted (only with macro; >=2)
// PORTS
//  s_axi_aclk     in   1     clock
//  s_axi_aresetn  in   1     reset: asynchronous, active-low
//  cmd_valid/cmd_ready  in/out  1  command handshake
//  cmd_write      in   1     1 = write, 0 = read
//  cmd_addr       in   AW    byte address
//  cmd_wdata      in   DW    write data
//  cmd_wstrb      in   DW/8  write strobes
//  rsp_valid/rsp_ready  out/in  1  response handshake
//  rsp_rdata      out  DW    read data (0 for writes)
//  rsp_resp       out  2     BRESP/RRESP as returned; 2'b10 on timeout
//  rsp_timeout    out  1     1 = transaction aborted by timeout
//  m_axi_aw{addr,prot,valid,ready} / m_axi_w{data,strb,valid,ready} / m_axi_b{resp,valid,ready}: AXI4-Lite write channels
//  m_axi_ar{addr,prot,valid,ready} / m_axi_r{data,resp,valid,ready}: AXI4-Lite read channels
//  m_axi_awprot / m_axi_arprot are constant 3'b000.
// BEHAVIOUR
//  Reset values:
//   - all valid/ready outputs 0, except cmd_ready = 1
//   - addr/data/strb/rsp_* = 0; state = IDLE
//   - reset mid-transaction abandons it silently: no response
//  All outputs are registered.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
//   - capture the command and drop cmd_ready
//   - write -> WR_REQ: awvalid and wvalid both = 1 the next cycle
//   - read  -> RD_REQ: arvalid = 1 the next cycle
//  WR_REQ:
//   - awvalid and wvalid each drop independently on their own handshake (either order, or same cycle)
//   - when both channels are done: bready = 1 -> WR_RESP
//   - address/data are stable while valid is high
//  WR_RESP: on bvalid & bready: rsp_resp = bresp, bready = 0 -> RSP.
//  RD_REQ: on arvalid & arready: arvalid = 0, rready = 1 -> RD_RESP.
//  RD_RESP: on rvalid & rready: rsp_rdata = rdata, rsp_resp = rresp, rready = 0 -> RSP.
//  RSP:
//   - rsp_valid = 1 and held, with rsp_* stable, until rsp_ready
//   - then rsp_valid = 0, cmd_ready = 1 -> IDLE
//   - a new command cannot be accepted in the same cycle as the response handshake
//  Best-case latency with a zero-wait slave: cmd accept -> rsp_valid = 4 cycles.
//  Error responses (SLVERR/DECERR) are passed through unchanged; never retried.
// CONFIGURATION
//  Macro AXI_LITE_CMD_MASTER_TIMEOUT_EN.
//  Defined:
//   - counter clears on command accept and increments in WR_REQ/WR_RESP/RD_REQ/RD_RESP
//   - at TIMEOUT_CYCLES: drop all m_axi valids/readies, rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0 -> RSP
//   - early valid drop is a deliberate debug-recovery exception to AXI
//  Undefined: no counter; waits indefinitely; rsp_timeout tied 0.
// STRUCTURE
//  Package axi_lite_pkg:
//   - resp_e: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11
//   - mst_state_e: the FSM states
//   - localparam PROT_DEFAULT = 3'b000
//  Single module; timeout counter stays inline, no sub-module.
// TESTING
//  Target for tests 1-3: the LED register slave at address 0x0.
//  1. Write addr 0x0, data 0x5, wstrb 0xF -> rsp_resp 00; led_out = 4'h5; rsp_rdata = 0.
//  2. Read addr 0x0 after test 1 -> rsp_rdata 0x00000005, rsp_resp 00, rsp_timeout 0.
//  3. Write addr 0x4 -> rsp_resp 2'b10; led_out unchanged; next read of 0x0 still returns 0x5.
//  4. BFM slave, wready 3 cycles before awready -> each valid drops on its own handshake;
//     exactly one AW and one W beat; bready rises only after both.
//  5. Hold rsp_ready low 10 cycles -> rsp_valid/rsp_* stable, cmd_ready 0; cmd_valid pulses ignored.
//  6. Macro on, TIMEOUT_CYCLES = 16, slave never asserts arready -> rsp_valid 16 cycles after entering RD_REQ;
//     rsp_resp 10, rsp_timeout 1. Then assert s_axi_aresetn low in WR_REQ -> all outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef logic [2:0] mst_state_e;

  localparam mst_state_e MstIdle   = 3'd0;
  localparam mst_state_e MstWrReq  = 3'd1;
  localparam mst_state_e MstWrResp = 3'd2;
  localparam mst_state_e MstRdReq  = 3'd3;
  localparam mst_state_e MstRdResp = 3'd4;
  localparam mst_state_e MstRsp    = 3'd5;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by the JTAG command decoder.
// Define AXI_LITE_CMD_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  mst_state_e                  state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic                        busy, accept, tmo_hit;

  assign busy   = (state_q == MstWrReq) || (state_q == MstWrResp) ||
                  (state_q == MstRdReq) || (state_q == MstRdResp);
  assign accept = (state_q == MstIdle) && cmd_valid && cmd_ready_q;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = busy && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (accept)    tmo_cnt_d = '0;
    else if (busy) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) tmo_cnt_q <= '0;
    else                tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      MstIdle: begin
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = MstWrReq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = MstRdReq;
          end
        end
      end
      MstWrReq: begin
        // AW and W complete independently; bready waits for both.
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = MstWrResp;
        end
      end
      MstWrResp: begin
        if (m_axi_bvalid) begin
          bready_d      = 1'b0;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = MstRsp;
        end
      end
      MstRdReq: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = MstRdResp;
        end
      end
      MstRdResp: begin
        if (m_axi_rvalid) begin
          rready_d      = 1'b0;
          rsp_rdata_d   = m_axi_rdata;
          rsp_resp_d    = m_axi_rresp;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = MstRsp;
        end
      end
      MstRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = MstIdle;
        end
      end
      default: begin
        state_d     = MstIdle;
        cmd_ready_d = 1'b1;
      end
    endcase
    // Debug recovery: abandon the bus transaction, even with valids still raised.
    if (tmo_hit && (state_d != MstRsp)) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_resp_d    = SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      state_d       = MstRsp;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= MstIdle;
      cmd_ready_q   <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: LED-register slave model, vector table and scoreboard.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Slave model: LED register at 0x0, SLVERR elsewhere; per-channel ready delays.
  int  aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit  aw_never = 0, w_never = 0, ar_never = 0;
  int  aw_cnt, w_cnt, ar_cnt;
  int  aw_beats = 0, w_beats = 0;
  bit  aw_got, w_got, ar_got;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [3:0]  led = 4'h0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; rvalid <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0; aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      s_awaddr <= 0; s_araddr <= 0; s_wdata <= 0; s_wstrb <= 0;
    end else begin
      awready <= 0; wready <= 0; arready <= 0;
      if (awvalid && awready) begin
        aw_got <= 1; s_awaddr <= awaddr; aw_beats <= aw_beats + 1;
      end else if (awvalid && !aw_got && !aw_never) begin
        if (aw_cnt >= aw_dly) begin awready <= 1; aw_cnt <= 0; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1; s_wdata <= wdata; s_wstrb <= wstrb; w_beats <= w_beats + 1;
      end else if (wvalid && !w_got && !w_never) begin
        if (w_cnt >= w_dly) begin wready <= 1; w_cnt <= 0; end
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1;
        bresp  <= (s_awaddr == 0) ? 2'b00 : 2'b10;
        if (s_awaddr == 0 && s_wstrb[0]) led <= s_wdata[3:0];
      end
      if (bvalid && bready) begin bvalid <= 0; aw_got <= 0; w_got <= 0; end
      if (arvalid && arready) begin
        ar_got <= 1; s_araddr <= araddr;
      end else if (arvalid && !ar_got && !ar_never) begin
        if (ar_cnt >= ar_dly) begin arready <= 1; ar_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (ar_got && !rvalid) begin
        rvalid <= 1;
        rdata  <= (s_araddr == 0) ? {28'h0, led} : 32'h0;
        rresp  <= (s_araddr == 0) ? 2'b00 : 2'b10;
      end
      if (rvalid && rready) begin rvalid <= 0; ar_got <= 0; end
    end
  end

  // Protocol monitors.
  int bready_early = 0, aw_late = 0, w_late = 0, split_seen = 0;
  always @(negedge clk) begin
    if (rstn) begin
      if (bready && !(aw_got && w_got)) bready_early++;
      if (awvalid && aw_got) aw_late++;
      if (wvalid && w_got) w_late++;
      if (awvalid && !wvalid) split_seen++;
    end
  end

  // Scoreboard.
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;
  exp_t sb_q[$];
  int   rsp_seen = 0;

  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("spurious_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
      rsp_seen++;
    end
  end

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [31:0] erd, input logic [1:0] eresp,
                         input logic eto, input bit wait_rsp);
    int n;
    int start;
    exp_t e;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      check("cmd_accept_bound", 64'(cmd_ready), 64'd1);
      cmd_valid = 0;
      return;
    end
    start = rsp_seen;
    e.rdata = erd; e.resp = eresp; e.to = eto;
    sb_q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 0;
    if (wait_rsp) begin
      n = 0;
      while (rsp_seen == start && n < 200) begin @(negedge clk); n++; end
      check("rsp_arrived", 64'(rsp_seen - start), 64'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          awd, wd, ard;
    logic [31:0] erdata;
    logic [1:0]  eresp;
    logic [3:0]  eled;
  } vec_t;
  vec_t vecs[9];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_aw;
    int n;
    exp_aw = 0;

    vecs[0] = '{1, 32'h0, 32'h5, 4'hF, 0, 0, 0, 32'h0, 2'b00, 4'h5};
    vecs[1] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 32'h5, 2'b00, 4'h5};
    vecs[2] = '{1, 32'h4, 32'hA, 4'hF, 0, 0, 0, 32'h0, 2'b10, 4'h5};
    vecs[3] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 1, 32'h5, 2'b00, 4'h5};
    vecs[4] = '{1, 32'h0, 32'hC, 4'hF, 3, 0, 0, 32'h0, 2'b00, 4'hC};
    vecs[5] = '{0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b10, 4'hC};
    vecs[6] = '{1, 32'h0, 32'h9, 4'hF, 0, 2, 0, 32'h0, 2'b00, 4'h9};
    vecs[7] = '{1, 32'h0, 32'h3, 4'h0, 1, 1, 0, 32'h0, 2'b00, 4'h9};
    vecs[8] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 2, 32'h9, 2'b00, 4'h9};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}),
          64'd0);
    check("rst_data", 64'({awaddr, wstrb, rsp_resp}) | 64'(wdata) | 64'(rsp_rdata), 64'd0);
    check("prot", 64'({awprot, arprot}), 64'd0);
    @(posedge clk); #1;
    rstn = 1;

    for (int i = 0; i < 9; i++) begin
      aw_dly = vecs[i].awd; w_dly = vecs[i].wd; ar_dly = vecs[i].ard;
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
              vecs[i].erdata, vecs[i].eresp, 1'b0, 1);
      if (vecs[i].wr) exp_aw++;
      check($sformatf("led_v%0d", i), 64'(led), 64'(vecs[i].eled));
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    check("split_drop_seen", 64'(split_seen != 0), 64'd1);

    // Response held while rsp_ready is low.
    rsp_ready = 0;
    run_cmd(0, 32'h0, 32'h0, 4'h0, 32'h9, 2'b00, 1'b0, 0);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("hold_rsp_valid_rise", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cmd_valid = i[0]; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'hF; cmd_wstrb = 4'hF;
      @(negedge clk);
      check($sformatf("hold_c%0d", i), 64'({rsp_valid, cmd_ready, rsp_resp, rsp_rdata}),
            64'({1'b1, 1'b0, 2'b00, 32'h9}));
    end
    @(posedge clk); #1;
    cmd_valid = 0; rsp_ready = 1;
    repeat (6) @(negedge clk);
    check("hold_no_new_cmd", 64'({awvalid, wvalid, arvalid}), 64'd0);
    check("hold_cmd_ready_back", 64'(cmd_ready), 64'd1);
    check("hold_sb_empty", 64'(sb_q.size()), 64'd0);
    check("hold_led_unchanged", 64'(led), 64'h9);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    ar_never = 1;
    run_cmd(0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 0);
    @(negedge clk);
    n = 0;
    while (!arvalid && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("tmo_latency", 64'(n), 64'd16);
    check("tmo_arvalid_dropped", 64'(arvalid), 64'd0);
    repeat (3) @(negedge clk);
    check("tmo_sb_empty", 64'(sb_q.size()), 64'd0);
    ar_never = 0;
`endif

    // Reset in the middle of a stalled write: abandoned silently.
    aw_never = 1; w_never = 1;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'h7; cmd_wstrb = 4'hF;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    check("wrreq_valids", 64'({awvalid, wvalid}), 64'b11);
    #1 rstn = 0;
    #1;
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("midrst_valids", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 64'd0);
    check("midrst_data", 64'({awaddr, wstrb}) | 64'(wdata), 64'd0);
    @(negedge clk);
    rstn = 1;
    aw_never = 0; w_never = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid) n++; end
    check("midrst_no_rsp", 64'(n), 64'd0);
    check("midrst_led", 64'(led), 64'h9);

    run_cmd(1, 32'h0, 32'h6, 4'hF, 32'h0, 2'b00, 1'b0, 1);
    exp_aw++;
    check("post_rst_led", 64'(led), 64'h6);

    check("aw_beats", 64'(aw_beats), 64'(exp_aw));
    check("w_beats", 64'(w_beats), 64'(exp_aw));
    check("bready_before_both", 64'(bready_early), 64'd0);
    check("awvalid_after_hs", 64'(aw_late), 64'd0);
    check("wvalid_after_hs", 64'(w_late), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
